// File: rtl/led_fader.sv
// rtl/led_fader.sv - command-driven RGB fade/hold sequencer feeding the pwm bright inputs
// Optional registered gamma output stage enabled by defining LED_FADER_GAMMA_EN.
module led_fader #(
  parameter int unsigned STEP_DIV = 187500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_rgb,
  input  logic [7:0]  cmd_hold,
  input  logic        abort,
  output logic [7:0]  bright_r,
  output logic [7:0]  bright_g,
  output logic [7:0]  bright_b,
  output logic        busy,
  output logic        done
);

  localparam logic [23:0] DIV_LAST = 24'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  lvl_r, lvl_g, lvl_b;
  logic [7:0]  lvl_r_nxt, lvl_g_nxt, lvl_b_nxt;
  logic [7:0]  tgt_r, tgt_g, tgt_b;
  logic [7:0]  tgt_r_nxt, tgt_g_nxt, tgt_b_nxt;
  logic [7:0]  hold_cnt, hold_cnt_nxt;
  logic [23:0] presc, presc_nxt;
  logic        done_nxt;
  logic        tick;
  logic        at_target;
  logic        accept;

  // Saturation is implicit: a level only moves toward a target that is itself in range.
  function automatic logic [7:0] step_toward(input logic [7:0] lvl, input logic [7:0] tgt);
    if (lvl < tgt)      return lvl + 8'd1;
    else if (lvl > tgt) return lvl - 8'd1;
    else                return lvl;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state != IDLE) && (presc == DIV_LAST);
  assign at_target = (lvl_r == tgt_r) && (lvl_g == tgt_g) && (lvl_b == tgt_b);

  always_comb begin
    state_nxt    = state;
    lvl_r_nxt    = lvl_r;
    lvl_g_nxt    = lvl_g;
    lvl_b_nxt    = lvl_b;
    tgt_r_nxt    = tgt_r;
    tgt_g_nxt    = tgt_g;
    tgt_b_nxt    = tgt_b;
    hold_cnt_nxt = hold_cnt;
    done_nxt     = 1'b0;
    // Prescaler freezes in IDLE so an abort does not disturb it; acceptance restarts it.
    if (state == IDLE) presc_nxt = presc;
    else if (tick)     presc_nxt = 24'd0;
    else               presc_nxt = presc + 24'd1;

    case (state)
      IDLE: begin
        if (accept) begin
          tgt_r_nxt    = cmd_rgb[23:16];
          tgt_g_nxt    = cmd_rgb[15:8];
          tgt_b_nxt    = cmd_rgb[7:0];
          hold_cnt_nxt = cmd_hold;
          presc_nxt    = 24'd0;
          state_nxt    = FADE;
        end
      end
      FADE: begin
        if (abort) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (at_target) begin
          state_nxt = HOLD;
          presc_nxt = 24'd0;
        end else if (tick) begin
          lvl_r_nxt = step_toward(lvl_r, tgt_r);
          lvl_g_nxt = step_toward(lvl_g, tgt_g);
          lvl_b_nxt = step_toward(lvl_b, tgt_b);
        end
      end
      HOLD: begin
        if (abort || (hold_cnt == 8'd0)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (tick) begin
          hold_cnt_nxt = hold_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lvl_r    <= 8'd0;
      lvl_g    <= 8'd0;
      lvl_b    <= 8'd0;
      tgt_r    <= 8'd0;
      tgt_g    <= 8'd0;
      tgt_b    <= 8'd0;
      hold_cnt <= 8'd0;
      presc    <= 24'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      lvl_r    <= lvl_r_nxt;
      lvl_g    <= lvl_g_nxt;
      lvl_b    <= lvl_b_nxt;
      tgt_r    <= tgt_r_nxt;
      tgt_g    <= tgt_g_nxt;
      tgt_b    <= tgt_b_nxt;
      hold_cnt <= hold_cnt_nxt;
      presc    <= presc_nxt;
      done     <= done_nxt;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  // Rounded-up square law: keeps 1 -> 1 so the dimmest step is still visible.
  function automatic logic [7:0] gamma8(input logic [7:0] lvl);
    logic [15:0] sq;
    sq = 16'(lvl) * 16'(lvl);
    sq = sq + 16'd255;
    return sq[15:8];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_r <= 8'd0;
      bright_g <= 8'd0;
      bright_b <= 8'd0;
    end else begin
      bright_r <= gamma8(lvl_r);
      bright_g <= gamma8(lvl_g);
      bright_b <= gamma8(lvl_b);
    end
  end
`else
  assign bright_r = lvl_r;
  assign bright_g = lvl_g;
  assign bright_b = lvl_b;
`endif

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - randomized self-checking bench for led_fader against a closed-form model
// Honours LED_FADER_GAMMA_EN when the design is built with it.
module tb_led_fader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_rgb = 24'd0;
  logic [7:0]  cmd_hold = 8'd0;
  logic        abort = 1'b0;
  logic [7:0]  bright_r, bright_g, bright_b;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_lvl [3];
  logic [7:0] m_prev [3];

  led_fader #(.STEP_DIV(S)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rgb(cmd_rgb), .cmd_hold(cmd_hold), .abort(abort),
    .bright_r(bright_r), .bright_g(bright_g), .bright_b(bright_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gam(input logic [7:0] l);
    int v;
    v = (int'(l) * int'(l) + 255) / 256;
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_bright(input int ch);
`ifdef LED_FADER_GAMMA_EN
    return gam(m_prev[ch]);
`else
    return m_lvl[ch];
`endif
  endfunction

  // Level after n whole steps from s toward t.
  function automatic logic [7:0] move(input logic [7:0] s, input logic [7:0] t, input int n);
    int si, ti;
    si = int'(s);
    ti = int'(t);
    if (ti >= si) return (ti - si > n) ? 8'(si + n) : t;
    else          return (si - ti > n) ? 8'(si - n) : t;
  endfunction

  task automatic check_outputs(input string tag, input bit exp_busy, input bit exp_done);
    check({tag, "_r"}, bright_r, exp_bright(0));
    check({tag, "_g"}, bright_g, exp_bright(1));
    check({tag, "_b"}, bright_b, exp_bright(2));
    check({tag, "_busy"}, busy, exp_busy);
    check({tag, "_ready"}, cmd_ready, !exp_busy);
    check({tag, "_done"}, done, exp_done);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = 1'($urandom);
      @(posedge clk);
      #1;
      m_prev = m_lvl;
      check_outputs("idle", 1'b0, 1'b0);
    end
  endtask

  // Starts at the negedge following the caller's last sample so a command can land in a done cycle.
  task automatic run_cmd(input logic [23:0] rgb, input logic [7:0] hold, input int abort_at,
                         input bit garbage, input int stop_after);
    logic [7:0] start [3];
    logic [7:0] tgt [3];
    int d, dur, endk, n;
    bit aborting;
    start = m_lvl;
    tgt[0] = rgb[23:16];
    tgt[1] = rgb[15:8];
    tgt[2] = rgb[7:0];
    d = 0;
    for (int c = 0; c < 3; c++) begin
      n = (int'(tgt[c]) > int'(start[c])) ? int'(tgt[c]) - int'(start[c]) : int'(start[c]) - int'(tgt[c]);
      if (n > d) d = n;
    end
    dur = 2 + (d + int'(hold)) * S;
    aborting = (abort_at > 0) && (abort_at <= dur);
    endk = aborting ? abort_at : dur;
    if (stop_after > 0 && stop_after < endk) endk = stop_after;

    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    abort = 1'b0;
    cmd_valid = 1'b1;
    cmd_rgb = rgb;
    cmd_hold = hold;
    @(posedge clk);
    #1;
    m_prev = m_lvl;
    check_outputs("accept", 1'b1, 1'b0);

    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      abort = aborting && (k == abort_at);
      cmd_valid = garbage;
      cmd_rgb = 24'($urandom);
      cmd_hold = 8'($urandom);
      @(posedge clk);
      #1;
      m_prev = m_lvl;
      n = (aborting && k >= abort_at) ? abort_at - 1 : k;
      for (int c = 0; c < 3; c++) m_lvl[c] = move(start[c], tgt[c], n / S);
      if (k == stop_after) check_outputs("run", 1'b1, 1'b0);
      else                 check_outputs("run", k != endk, k == endk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_lvl[c] = 8'd0;
      m_prev[c] = 8'd0;
    end
    #7;
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Basic fade, then build 0x050505 and decrement with hold.
    run_cmd(24'h030001, 8'd0, 0, 1'b0, 0);
    run_cmd(24'h050505, 8'd0, 0, 1'b0, 0);
    run_cmd(24'h030505, 8'd2, 0, 1'b1, 0);
    // Same-target command, accepted in the done cycle of the previous one.
    run_cmd(24'h030505, 8'd0, 0, 1'b0, 0);
    check("same_target_r", bright_r, exp_bright(0));
    idle(1);

    // Abort at R=2 while heading to 200, with cmd_valid held during busy.
    run_cmd(24'h000000, 8'd0, 0, 1'b0, 0);
    run_cmd(24'hC80000, 8'd0, 10, 1'b1, 0);
    check("abort_frozen_r", m_lvl[0], 8'd2);
    idle(3);

    for (int i = 0; i < 10; i++) begin
      run_cmd(24'($urandom), 8'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 600)) : 0,
              1'($urandom), 0);
      idle(int'($urandom_range(0, 2)));
    end

    // Full-scale ramp exercises the gamma mapping at 128 and 255.
    run_cmd(24'h000000, 8'd0, 0, 1'b0, 0);
    run_cmd(24'hFFFFFF, 8'd1, 0, 1'b0, 0);
    idle(1);
    check("ramp_final_r", bright_r, 8'd255);

    // Reset mid-fade once lvl_r has reached 10.
    run_cmd(24'h000000, 8'd0, 0, 1'b0, 0);
    run_cmd(24'hC80000, 8'd0, 0, 1'b0, 41);
    check("pre_reset_lvl_r", m_lvl[0], 8'd10);
    #2;
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      m_lvl[c] = 8'd0;
      m_prev[c] = 8'd0;
    end
    check_outputs("mid_reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
